// File: rtl/maccum_sched_pkg.sv
// maccum_sched_pkg: shared state/tag types and bus-width helpers for maccum_sched.
package maccum_sched_pkg;
  typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_e;
  typedef logic tag_t;
  function automatic int wb_w(input int np, input int nc, input int wf);
    return np * nc * wf + nc * wf;
  endfunction
  function automatic int st_w(input int np, input int wf);
    return np * wf;
  endfunction
  function automatic int ac_w(input int np, input int nc, input int wf);
    return nc * ($clog2(np) + wf);
  endfunction
endpackage

// File: rtl/maccum_sched_if.sv
// maccum_sched_if: requester, Maccum-side and result handshake buses of maccum_sched.
interface maccum_sched_if
  import maccum_sched_pkg::*;
#(
  parameter int NP = 3,
  parameter int NC = 2,
  parameter int WF = 8
);
  localparam int WB = wb_w(NP, NC, WF);
  localparam int ST = st_w(NP, WF);
  localparam int AC = ac_w(NP, NC, WF);
  logic          iValid_AM_Job0, iValid_AM_Job1;
  logic          oReady_AM_Job0, oReady_AM_Job1;
  logic [WB-1:0] iData_AM_WeightBias0, iData_AM_WeightBias1;
  logic [ST-1:0] iData_AM_State0, iData_AM_State1;
  logic          oValid_BM_Result0, oValid_BM_Result1;
  logic          iReady_BM_Result0, iReady_BM_Result1;
  logic [AC-1:0] oData_BM_Result0, oData_BM_Result1;
  logic          oValid_BM_WeightBias, iReady_BM_WeightBias;
  logic [WB-1:0] oData_BM_WeightBias;
  logic          oValid_BM_StateM, iReady_BM_StateM;
  logic [ST-1:0] oData_BM_StateM;
  logic          iValid_AM_Accum0, oReady_AM_Accum0;
  logic [AC-1:0] iData_AM_Accum0;
  modport master (
    input  iValid_AM_Job0, iValid_AM_Job1, iData_AM_WeightBias0, iData_AM_WeightBias1,
           iData_AM_State0, iData_AM_State1, iReady_BM_Result0, iReady_BM_Result1,
           iReady_BM_WeightBias, iReady_BM_StateM, iValid_AM_Accum0, iData_AM_Accum0,
    output oReady_AM_Job0, oReady_AM_Job1, oValid_BM_Result0, oValid_BM_Result1,
           oData_BM_Result0, oData_BM_Result1, oValid_BM_WeightBias, oData_BM_WeightBias,
           oValid_BM_StateM, oData_BM_StateM, oReady_AM_Accum0
  );
  modport slave (
    output iValid_AM_Job0, iValid_AM_Job1, iData_AM_WeightBias0, iData_AM_WeightBias1,
           iData_AM_State0, iData_AM_State1, iReady_BM_Result0, iReady_BM_Result1,
           iReady_BM_WeightBias, iReady_BM_StateM, iValid_AM_Accum0, iData_AM_Accum0,
    input  oReady_AM_Job0, oReady_AM_Job1, oValid_BM_Result0, oValid_BM_Result1,
           oData_BM_Result0, oData_BM_Result1, oValid_BM_WeightBias, oData_BM_WeightBias,
           oValid_BM_StateM, oData_BM_StateM, oReady_AM_Accum0
  );
endinterface

// File: rtl/maccum_tag_fifo.sv
// maccum_tag_fifo: in-order FIFO of 1-bit requester tags with full/empty flags.
module maccum_tag_fifo
  import maccum_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  tag_t tag_i,
  input  logic pop_i,
  output tag_t head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  tag_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wp_q] = tag_i;
    wp_d  = push_i ? wp_q + 1'b1 : wp_q;
    rp_d  = pop_i ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  assign head_o  = mem_q[rp_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/maccum_sched.sv
// maccum_sched: two-requester job scheduler sharing one Maccum, results routed back by tag.
// Define MACCUM_SCHED_PRIO_EN for strict R0 priority instead of round-robin.
module maccum_sched
  import maccum_sched_pkg::*;
#(
  parameter int NP    = 3,
  parameter int NC    = 2,
  parameter int WF    = 8,
  parameter int DEPTH = 4
) (
  input  logic iCLK,
  input  logic iRST,
  maccum_sched_if.master bus
);
  localparam int WB = wb_w(NP, NC, WF);
  localparam int ST = st_w(NP, WF);
  localparam logic [0:0] IDLE  = 1'(ST_IDLE);
  localparam logic [0:0] ISSUE = 1'(ST_ISSUE);
  logic [0:0]    state_q, state_d;
  logic          wb_done_q, wb_done_d, st_done_q, st_done_d;
  logic [WB-1:0] wb_q, wb_d;
  logic [ST-1:0] st_q, st_d;
  logic          v_wb, v_st, wb_hs, st_hs, acc, full, empty, pop;
  tag_t          win, head;
`ifdef MACCUM_SCHED_PRIO_EN
  assign win = !bus.iValid_AM_Job0;
`else
  logic lp_q, lp_d;
  assign win  = (bus.iValid_AM_Job0 & bus.iValid_AM_Job1) ? !lp_q : bus.iValid_AM_Job1;
  assign lp_d = acc ? win : lp_q;
  // lp starts at 1 so R0 takes the first tie
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) lp_q <= 1'b1;
    else lp_q <= lp_d;
`endif
  assign acc   = iRST & (state_q == IDLE) & !full & (bus.iValid_AM_Job0 | bus.iValid_AM_Job1);
  assign v_wb  = (state_q == ISSUE) & !wb_done_q;
  assign v_st  = (state_q == ISSUE) & !st_done_q;
  assign wb_hs = v_wb & bus.iReady_BM_WeightBias;
  assign st_hs = v_st & bus.iReady_BM_StateM;
  always_comb begin
    state_d   = acc ? ISSUE :
                ((state_q == ISSUE) & (wb_done_q | wb_hs) & (st_done_q | st_hs)) ? IDLE : state_q;
    wb_done_d = acc ? 1'b0 : wb_done_q | wb_hs;
    st_done_d = acc ? 1'b0 : st_done_q | st_hs;
    wb_d      = acc ? (win ? bus.iData_AM_WeightBias1 : bus.iData_AM_WeightBias0) : wb_q;
    st_d      = acc ? (win ? bus.iData_AM_State1 : bus.iData_AM_State0) : st_q;
  end
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state_q   <= IDLE;
      wb_done_q <= 1'b0;
      st_done_q <= 1'b0;
      wb_q      <= '0;
      st_q      <= '0;
    end else begin
      state_q   <= state_d;
      wb_done_q <= wb_done_d;
      st_done_q <= st_done_d;
      wb_q      <= wb_d;
      st_q      <= st_d;
    end
  maccum_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(iCLK), .rst_n(iRST), .push_i(acc), .tag_i(win), .pop_i(pop),
    .head_o(head), .full_o(full), .empty_o(empty)
  );
  assign bus.oReady_AM_Job0       = acc & !win;
  assign bus.oReady_AM_Job1       = acc & win;
  assign bus.oValid_BM_WeightBias = v_wb;
  assign bus.oValid_BM_StateM     = v_st;
  assign bus.oData_BM_WeightBias  = wb_q;
  assign bus.oData_BM_StateM      = st_q;
  // results are matched to requesters purely by issue order
  assign bus.oValid_BM_Result0    = bus.iValid_AM_Accum0 & !empty & !head;
  assign bus.oValid_BM_Result1    = bus.iValid_AM_Accum0 & !empty & head;
  assign bus.oData_BM_Result0     = bus.iData_AM_Accum0;
  assign bus.oData_BM_Result1     = bus.iData_AM_Accum0;
  assign bus.oReady_AM_Accum0     = !empty & (head ? bus.iReady_BM_Result1 : bus.iReady_BM_Result0);
  assign pop                      = bus.iValid_AM_Accum0 & bus.oReady_AM_Accum0;
endmodule

// File: tb/tb_maccum_sched.sv
// tb_maccum_sched: randomized scoreboard bench for maccum_sched against a queue-based job model.
module tb_maccum_sched;
  import maccum_sched_pkg::*;
  localparam int NP = 3, NC = 2, WF = 8, DEPTH = 4;
  localparam int WB = wb_w(NP, NC, WF);
  localparam int ST = st_w(NP, WF);
  localparam int AC = ac_w(NP, NC, WF);
  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;
  maccum_sched_if #(.NP(NP), .NC(NC), .WF(WF)) bus ();
  maccum_sched #(.NP(NP), .NC(NC), .WF(WF), .DEPTH(DEPTH)) dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));

  int checks = 0, passes = 0;
  logic [WB-1:0] exp_wb_q[$];
  logic [ST-1:0] exp_st_q[$];
  logic [AC:0]   exp_res_q[$];
  bit m_busy, m_wbp, m_stp, m_lp;
  bit m_tags[$];
  bit e_r0, e_r1, e_vwb, e_vst, e_vr0, e_vr1, e_racc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_wbp = 0; m_stp = 0; m_lp = 1;
    m_tags.delete(); exp_wb_q.delete(); exp_st_q.delete(); exp_res_q.delete();
    {e_r0, e_r1, e_vwb, e_vst, e_vr0, e_vr1, e_racc} = '0;
  endtask

  task automatic drive(input bit v0, v1, input logic [WB-1:0] w0, w1, input logic [ST-1:0] s0, s1,
                       input bit rw, rs, va, input logic [AC-1:0] ad, input bit rr0, rr1);
    bus.iValid_AM_Job0 = v0; bus.iValid_AM_Job1 = v1;
    bus.iData_AM_WeightBias0 = w0; bus.iData_AM_WeightBias1 = w1;
    bus.iData_AM_State0 = s0; bus.iData_AM_State1 = s1;
    bus.iReady_BM_WeightBias = rw; bus.iReady_BM_StateM = rs;
    bus.iValid_AM_Accum0 = va; bus.iData_AM_Accum0 = ad;
    bus.iReady_BM_Result0 = rr0; bus.iReady_BM_Result1 = rr1;
  endtask

  // one clock of stimulus: predict this cycle's outputs, then apply the job-level effects of the next edge
  task automatic cycle(input bit v0, v1, input logic [WB-1:0] w0, w1, input logic [ST-1:0] s0, s1,
                       input bit rw, rs, va, input logic [AC-1:0] ad, input bit rr0, rr1);
    bit can, w, hv, hd;
    @(posedge iCLK); #1;
    drive(v0, v1, w0, w1, s0, s1, rw, rs, va, ad, rr0, rr1);
    can = !m_busy && m_tags.size() < DEPTH && (v0 || v1);
`ifdef MACCUM_SCHED_PRIO_EN
    w = !v0;
`else
    w = (v0 && v1) ? !m_lp : v1;
`endif
    e_r0 = can && !w; e_r1 = can && w;
    e_vwb = m_busy && m_wbp; e_vst = m_busy && m_stp;
    hv = m_tags.size() > 0;
    hd = hv ? m_tags[0] : 1'b0;
    e_vr0 = va && hv && !hd; e_vr1 = va && hv && hd;
    e_racc = hv && (hd ? rr1 : rr0);
    if (va && e_racc) begin
      exp_res_q.push_back({hd, ad});
      void'(m_tags.pop_front());
    end
    if (can) begin
      exp_wb_q.push_back(w ? w1 : w0);
      exp_st_q.push_back(w ? s1 : s0);
      m_tags.push_back(w);
      m_lp = w; m_busy = 1; m_wbp = 1; m_stp = 1;
    end else if (m_busy) begin
      if (rw) m_wbp = 0;
      if (rs) m_stp = 0;
      if (!m_wbp && !m_stp) m_busy = 0;
    end
  endtask

  task automatic rnd_cycle(input int pv, input int pr, input int pa);
    cycle($urandom_range(99) < pv, $urandom_range(99) < pv,
          {$urandom, $urandom}, {$urandom, $urandom}, ST'($urandom), ST'($urandom),
          $urandom_range(99) < pr, $urandom_range(99) < pr, $urandom_range(99) < pa,
          AC'($urandom), $urandom_range(99) < pr, $urandom_range(99) < pr);
  endtask

  // hold reset with every request asserted; outputs must stay quiet and state must clear
  task automatic rst_hold(input int n);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    model_reset();
    drive(1, 1, '1, '1, '1, '1, 1, 1, 1, '1, 1, 1);
    repeat (n) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    drive(0, 0, '0, '0, '0, '0, 0, 0, 0, '0, 0, 0);
    #1;
    chk("wb_reg_reset", bus.oData_BM_WeightBias, '0);
    chk("st_reg_reset", bus.oData_BM_StateM, '0);
  endtask

  always @(negedge iCLK) begin
    chk("job_ready0", bus.oReady_AM_Job0, e_r0);
    chk("job_ready1", bus.oReady_AM_Job1, e_r1);
    chk("wb_valid", bus.oValid_BM_WeightBias, e_vwb);
    chk("st_valid", bus.oValid_BM_StateM, e_vst);
    chk("res_valid0", bus.oValid_BM_Result0, e_vr0);
    chk("res_valid1", bus.oValid_BM_Result1, e_vr1);
    chk("accum_ready", bus.oReady_AM_Accum0, e_racc);
    if (bus.oValid_BM_WeightBias && bus.iReady_BM_WeightBias) begin
      chk("wb_pending", exp_wb_q.size() > 0, 1);
      if (exp_wb_q.size() > 0) chk("wb_data", bus.oData_BM_WeightBias, exp_wb_q.pop_front());
    end
    if (bus.oValid_BM_StateM && bus.iReady_BM_StateM) begin
      chk("st_pending", exp_st_q.size() > 0, 1);
      if (exp_st_q.size() > 0) chk("st_data", bus.oData_BM_StateM, exp_st_q.pop_front());
    end
    if ((bus.oValid_BM_Result0 && bus.iReady_BM_Result0) || (bus.oValid_BM_Result1 && bus.iReady_BM_Result1)) begin
      chk("res_pending", exp_res_q.size() > 0, 1);
      if (exp_res_q.size() > 0)
        chk("res_route", {bus.oValid_BM_Result1, bus.oValid_BM_Result1 ? bus.oData_BM_Result1 : bus.oData_BM_Result0},
            exp_res_q.pop_front());
    end
  end

  initial begin
    logic [WB-1:0] wb_t;
    logic [ST-1:0] st_t;
    wb_t = {8'd32, 8'd22, 8'd12, 8'd31, 8'd21, 8'd11, 8'd22, 8'd11};
    st_t = {8'd103, 8'd102, 8'd101};
    model_reset();
    drive(0, 0, '0, '0, '0, '0, 0, 0, 0, '0, 0, 0);
    rst_hold(3);
    // tie at reset, then State ready lags WeightBias by 3 cycles, then its result
    cycle(1, 1, wb_t, ~wb_t, st_t, ~st_t, 0, 0, 0, '0, 0, 0);
    cycle(0, 0, '0, '0, '0, '0, 1, 0, 0, '0, 0, 0);
    repeat (2) cycle(0, 0, '0, '0, '0, '0, 1, 0, 0, '0, 0, 0);
    cycle(0, 0, '0, '0, '0, '0, 1, 1, 0, '0, 0, 0);
    cycle(0, 0, '0, '0, '0, '0, 0, 0, 1, 20'h5a5a5, 1, 1);
    // sustained tie with fast Maccum to show grant alternation
    repeat (12) cycle(1, 1, {$urandom, $urandom}, {$urandom, $urandom}, ST'($urandom), ST'($urandom),
                      1, 1, 1, AC'($urandom), 1, 1);
    // spurious Accum0 with nothing outstanding
    repeat (3) cycle(0, 0, '0, '0, '0, '0, 0, 0, 1, AC'($urandom), 1, 1);
    // fill the tag FIFO with results held off, then drain under result backpressure
    repeat (30) rnd_cycle(90, 100, 0);
    repeat (60) rnd_cycle(0, 50, 100);
    repeat (300) rnd_cycle(50, 70, 50);
    repeat (200) rnd_cycle(80, 30, 30);
    // reset while jobs are queued and one is in flight
    repeat (8) rnd_cycle(90, 20, 0);
    rst_hold(1);
    cycle(0, 1, '0, {$urandom, $urandom}, '0, ST'($urandom), 1, 1, 0, '0, 0, 0);
    repeat (2) cycle(0, 0, '0, '0, '0, '0, 1, 1, 0, '0, 0, 0);
    cycle(0, 0, '0, '0, '0, '0, 0, 0, 1, AC'($urandom), 1, 1);
    repeat (300) rnd_cycle(60, 60, 60);
    @(posedge iCLK); #1;
    drive(0, 0, '0, '0, '0, '0, 0, 0, 0, '0, 0, 0);
    {e_r0, e_r1, e_vr0, e_vr1, e_racc} = '0;
    e_vwb = m_busy && m_wbp; e_vst = m_busy && m_stp;
    @(negedge iCLK); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/maccum_sched.md
# maccum_sched

Two-requester scheduler sharing one `Maccum` instance (multiply-accumulate, NP inputs × NC outputs). Each requester submits a job: a weight/bias vector plus a state vector. Jobs are arbitrated, issued to the Maccum WeightBias and State0 input channels, and tagged in an in-order FIFO. The Maccum `Accum0` result is routed back to the requester that issued it; `Accum1` is not handled by this block.

## Interface
- NP, 3, number of Maccum inputs (previous layer width)
- NC, 2, number of Maccum outputs (current layer width)
- WF, 8, fixed-point word width
- DEPTH, 4, maximum outstanding jobs (power of 2, ≥2)
- Widths: WB = NP·NC·WF+NC·WF, ST = NP·WF, AC = NC·($clog2(NP)+WF)
- iCLK  in  1  clock
- iRST  in  1  asynchronous, active-low reset
- iValid_AM_Job0 / iValid_AM_Job1  in  1  job request
- oReady_AM_Job0 / oReady_AM_Job1  out  1  job accepted
- iData_AM_WeightBias0 / iData_AM_WeightBias1  in  WB  job weights and biases
- iData_AM_State0 / iData_AM_State1  in  ST  job state vector
- oValid_BM_Result0 / oValid_BM_Result1  out  1  result valid
- iReady_BM_Result0 / iReady_BM_Result1  in  1  result taken
- oData_BM_Result0 / oData_BM_Result1  out  AC  accumulated result
- oValid_BM_WeightBias, iReady_BM_WeightBias, oData_BM_WeightBias  out/in/out  1/1/WB  to Maccum
- oValid_BM_StateM, iReady_BM_StateM, oData_BM_StateM  out/in/out  1/1/ST  to Maccum State0
- iValid_AM_Accum0, oReady_AM_Accum0, iData_AM_Accum0  in/out/in  1/1/AC  from Maccum

## Operation
- **FSM states:** IDLE and ISSUE.
- **IDLE:**
  - A winner is selected when the tag FIFO is not full and at least one iValid_AM_Job is high.
  - oReady_AM_Job{w} is high combinationally for the winner only.
  - On the handshake:
    - latch both payloads into output registers;
    - push tag w into the FIFO;
    - clear the wb_done and st_done flags;
    - go to ISSUE.
- **ISSUE:**
  - oValid_BM_WeightBias = !wb_done and oValid_BM_StateM = !st_done.
  - Each handshake sets its done flag. The two channels complete independently, in either order or in the same cycle.
  - When both channels are done (counting handshakes in the current cycle), return to IDLE.
  - No job is accepted while in ISSUE.
- **Arbitration:** round-robin with a last-grant pointer lp.
  - If both requesters are valid, grant !lp.
  - lp updates to w on each accept.
- **Result routing:** head = FIFO head tag.
  - oValid_BM_Result{r} = iValid_AM_Accum0 & !empty & (head==r).
  - Both oData_BM_Result buses carry iData_AM_Accum0.
  - oReady_AM_Accum0 = !empty & iReady_BM_Result{head}.
  - The FIFO pops on the Accum0 handshake.
- **Boundary conditions:**
  - Accum0 valid while the FIFO is empty: not accepted (ready 0), held off indefinitely.
  - FIFO full: no accept. A pop in the same cycle does not enable the accept; it is allowed from the next cycle.
  - Push and pop in the same cycle: count unchanged.
  - A requester dropping valid before its grant is legal; it has no effect.
- **Reset mid-operation:** FSM, lp, flags, FIFO and output registers clear immediately. Outstanding jobs are lost; the Maccum shares this reset.

## Timing
- **Reset values:**
  - all oValid and oReady outputs 0 while iRST is low;
  - after reset: state IDLE, lp=1 (R0 wins the first tie), FIFO empty, data registers 0.
- **Issue latency:** accept at edge k → both Maccum-side valids high in cycle k+1.
- **Minimum job period:** 2 cycles (IDLE→ISSUE→IDLE).
- **Result path:** zero latency, purely combinational.
- **Data stability:** oData_BM_WeightBias and oData_BM_StateM stay stable while their valid is high.

## Configuration
- **MACCUM_SCHED_PRIO_EN defined:** strict priority. R0 always wins; R1 is granted only when R0 is not valid; lp is unused.
- **Undefined:** round-robin as described in Operation.

## Structure
- **Package maccum_sched_pkg:**
  - state enum {IDLE, ISSUE};
  - tag typedef (1 bit);
  - width functions for WB, ST and AC.
- **Sub-module maccum_tag_fifo:** 1-bit wide, DEPTH deep, in-order, with full/empty flags and count. It is the only sub-module.

## Test plan
- **Single job:** R0 sends WB {32,22,12,31,21,11,22,11}, state {103,102,101}.
  - Maccum ports see identical data from the cycle after accept.
  - Accum0 result X appears only on Result0.
- **Tie:** both requesters valid at reset.
  - Round-robin: grant order R0,R1,R0,R1.
  - With MACCUM_SCHED_PRIO_EN: R0,R0,R0 while R0 stays valid.
- **Skewed Maccum readies:** iReady_BM_StateM delayed 3 cycles after iReady_BM_WeightBias.
  - FSM stays in ISSUE until the State handshake; WeightBias valid drops after its own handshake.
- **Backpressure:** issue DEPTH=4 jobs (R0,R1,R1,R0) with Accum0 held off.
  - 5th request not accepted.
  - Results return in order R0,R1,R1,R0.
  - Result1 held with iReady_BM_Result1=0 stalls oReady_AM_Accum0.
- **Spurious result:** Accum0 valid with the FIFO empty → oReady_AM_Accum0=0 and no Result valid.
- **Reset mid-operation:** assert iRST low while in ISSUE with 2 tags queued → all valids 0 and FIFO empty next cycle; the next R1 job routes correctly.
